// File: rtl/ldst_pkg.sv
// ldst_pkg: shared definitions for the ex3 load/store data-phase stage.
//   - memop encodings (stores 1..3, loads 9..D; bit 3 marks a load)
//   - AHB HTRANS codes used by the stage
//   - data-phase FSM state enum
//   - load_extend(): sign/zero extension of already-shifted read data
// The extension works on a 64-bit container so any XLEN up to 64 can use it;
// callers pad the input with zeros and keep the low XLEN bits of the result.
package ldst_pkg;

    localparam logic [3:0] MEMOP_SB  = 4'h1;
    localparam logic [3:0] MEMOP_SH  = 4'h2;
    localparam logic [3:0] MEMOP_SW  = 4'h3;
    localparam logic [3:0] MEMOP_LB  = 4'h9;
    localparam logic [3:0] MEMOP_LBU = 4'hA;
    localparam logic [3:0] MEMOP_LH  = 4'hB;
    localparam logic [3:0] MEMOP_LHU = 4'hC;
    localparam logic [3:0] MEMOP_LW  = 4'hD;

    localparam logic [1:0] HTRANS_IDLE   = 2'h0;
    localparam logic [1:0] HTRANS_NONSEQ = 2'h2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    function automatic logic memop_is_store(input logic [3:0] memop);
        return (memop == MEMOP_SB) || (memop == MEMOP_SH) || (memop == MEMOP_SW);
    endfunction

    function automatic logic memop_is_load(input logic [3:0] memop);
        return (memop >= MEMOP_LB) && (memop <= MEMOP_LW);
    endfunction

    function automatic logic [63:0] load_extend(input logic [3:0] memop, input logic [63:0] sh);
        logic [63:0] r;
        r = '0;
        case (memop)
            MEMOP_LB:  r = {{56{sh[7]}},  sh[7:0]};
            MEMOP_LBU: r = {56'd0,        sh[7:0]};
            MEMOP_LH:  r = {{48{sh[15]}}, sh[15:0]};
            MEMOP_LHU: r = {48'd0,        sh[15:0]};
            MEMOP_LW:  r = sh;
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex3_load_align_t.sv
// ex3_load_align_t: combinational load alignment.
//   hrdata  in  XLEN  raw bus read data
//   off     in  2     byte offset (addr[1:0]) of the load
//   memop   in  4     load memop selecting width and signedness
//   data    out XLEN  shifted and extended load result
// Misaligned offsets are not trapped; the data is simply shifted by 8*off.
module ex3_load_align_t
    import ldst_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] hrdata,
    input  logic [1:0]      off,
    input  logic [3:0]      memop,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] sh;
    logic [63:0]     sh_w;
    logic [63:0]     ext;

    assign sh = hrdata >> {off, 3'b000};

    always_comb begin
        sh_w            = '0;
        sh_w[XLEN-1:0]  = sh;
        ext             = load_extend(memop, sh_w);
        data            = ext[XLEN-1:0];
    end

endmodule

// File: rtl/ex3_ldst_dphase_t.sv
// ex3_ldst_dphase_t: AHB-Lite data-phase stage of the load/store path.
// Captures each accepted address beat from ex2, drives HWDATA for stores,
// aligns/extends HRDATA for loads, stalls the pipe during wait states and
// reports ERROR responses.
//
// Ports
//   CLK, RST            clock; synchronous active-high reset
//   ldst2_ahb_HTRANS/HWRITE/HADDR    address-phase beat from ex2
//   r_ex2_memop_Q, s_ex2_encoded_Q, s_ex2_rd_Q   beat attributes from ex2
//   ldst2_ahb_HREADY/HRESP/HRDATA    data-phase bus response
//   s_ex3_flush         kill the in-flight result (bus beat still completes)
//   ldst2_ahb_HWDATA    store data during the data phase
//   s_ex3_stall_D       data phase pending and not completing this cycle
//   s_ex3_wb_valid_D/rd_D/data_D     load write-back (one-cycle pulse)
//   s_ex3_exc_D/exc_addr_D           bus error pulse and faulting address
//
// Build option: EX3_LOAD_REG_EN registers the write-back outputs (+1 cycle).
// Without it they are combinational in the completion cycle.
module ex3_ldst_dphase_t
    import ldst_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [1:0]      ldst2_ahb_HTRANS,
    input  logic            ldst2_ahb_HWRITE,
    input  logic [XLEN-1:0] ldst2_ahb_HADDR,
    input  logic [3:0]      r_ex2_memop_Q,
    input  logic [XLEN-1:0] s_ex2_encoded_Q,
    input  logic [RD_W-1:0] s_ex2_rd_Q,
    input  logic            ldst2_ahb_HREADY,
    input  logic            ldst2_ahb_HRESP,
    input  logic [XLEN-1:0] ldst2_ahb_HRDATA,
    input  logic            s_ex3_flush,
    output logic [XLEN-1:0] ldst2_ahb_HWDATA,
    output logic            s_ex3_stall_D,
    output logic            s_ex3_wb_valid_D,
    output logic [RD_W-1:0] s_ex3_wb_rd_D,
    output logic [XLEN-1:0] s_ex3_wb_data_D,
    output logic            s_ex3_exc_D,
    output logic [XLEN-1:0] s_ex3_exc_addr_D
);

    state_e          state_q, state_d;
    logic [3:0]      memop_q;
    logic [XLEN-1:0] addr_q;
    logic [RD_W-1:0] rd_q;
    logic [XLEN-1:0] wdata_q;
    logic            hwrite_q;
    logic            kill_q, kill_d;

    logic            accept;
    logic            take;
    logic            complete;
    logic            err_exit;
    logic            kill_eff;
    logic [XLEN-1:0] load_data;

    logic            wb_valid_c;
    logic [RD_W-1:0] wb_rd_c;
    logic [XLEN-1:0] wb_data_c;

    assign accept   = ldst2_ahb_HREADY && (ldst2_ahb_HTRANS == HTRANS_NONSEQ);
    assign complete = (state_q == ST_DATA) && ldst2_ahb_HREADY && !ldst2_ahb_HRESP;
    assign err_exit = (state_q == ST_ERR)  && ldst2_ahb_HREADY &&  ldst2_ahb_HRESP;
    // A new beat is only latched when the data-phase slot is free this cycle:
    // from IDLE, or overlapping the completion of the previous beat.
    assign take     = accept && ((state_q == ST_IDLE) || complete);
    // Flush in the retiring cycle itself also kills the result.
    assign kill_eff = kill_q || s_ex3_flush;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_DATA;
            ST_DATA: begin
                if (ldst2_ahb_HREADY && !ldst2_ahb_HRESP)
                    state_d = accept ? ST_DATA : ST_IDLE;
                else if (!ldst2_ahb_HREADY && ldst2_ahb_HRESP)
                    state_d = ST_ERR;
            end
            // Only the second ERROR cycle leaves ERR; anything else holds.
            ST_ERR:  if (err_exit) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        kill_d = kill_q;
        if (complete || err_exit)
            kill_d = 1'b0;
        else if ((state_q != ST_IDLE) && s_ex3_flush)
            kill_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            memop_q  <= '0;
            addr_q   <= '0;
            rd_q     <= '0;
            wdata_q  <= '0;
            hwrite_q <= 1'b0;
            kill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            if (take) begin
                memop_q  <= r_ex2_memop_Q;
                addr_q   <= ldst2_ahb_HADDR;
                rd_q     <= s_ex2_rd_Q;
                wdata_q  <= s_ex2_encoded_Q;
                hwrite_q <= ldst2_ahb_HWRITE;
            end
        end
    end

    ex3_load_align_t #(.XLEN(XLEN)) u_align (
        .hrdata (ldst2_ahb_HRDATA),
        .off    (addr_q[1:0]),
        .memop  (memop_q),
        .data   (load_data)
    );

    // Write data is held from the latch, so it stays stable across wait states.
    assign ldst2_ahb_HWDATA = ((state_q != ST_IDLE) && hwrite_q && memop_is_store(memop_q))
                              ? wdata_q : '0;

    assign s_ex3_stall_D = (state_q != ST_IDLE) && !(ldst2_ahb_HREADY && !ldst2_ahb_HRESP);

    // Pulses are gated by RST so a reset landing on a completion drops the beat.
    assign wb_valid_c = complete && memop_is_load(memop_q) && !kill_eff && !RST;
    assign wb_rd_c    = wb_valid_c ? rd_q : '0;
    assign wb_data_c  = wb_valid_c ? load_data : '0;

    assign s_ex3_exc_D      = err_exit && !kill_eff && !RST;
    assign s_ex3_exc_addr_D = s_ex3_exc_D ? addr_q : '0;

`ifdef EX3_LOAD_REG_EN
    logic            wb_valid_q;
    logic [RD_W-1:0] wb_rd_q;
    logic [XLEN-1:0] wb_data_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_c;
            wb_rd_q    <= wb_rd_c;
            wb_data_q  <= wb_data_c;
        end
    end

    assign s_ex3_wb_valid_D = wb_valid_q;
    assign s_ex3_wb_rd_D    = wb_rd_q;
    assign s_ex3_wb_data_D  = wb_data_q;
`else
    assign s_ex3_wb_valid_D = wb_valid_c;
    assign s_ex3_wb_rd_D    = wb_rd_c;
    assign s_ex3_wb_data_D  = wb_data_c;
`endif

endmodule

// File: tb/tb_ex3_ldst_dphase_t.sv
module tb_ex3_ldst_dphase_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [3:0]  memop;
    logic [31:0] enc;
    logic [4:0]  rd;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic        flush;
    logic [31:0] hwdata;
    logic        stall;
    logic        wb_v;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc;
    logic [31:0] exc_addr;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level reference: the beat currently owning the data phase.
    bit          m_busy, m_err, m_kill;
    logic [3:0]  m_memop;
    logic [31:0] m_addr, m_wdata;
    logic [4:0]  m_rd;
    // Previous-cycle expectations for the registered write-back build.
    logic        d_v;
    logic [4:0]  d_rd;
    logic [31:0] d_data;

    always #5 CLK = ~CLK;

    ex3_ldst_dphase_t #(.XLEN(32), .RD_W(5)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .ldst2_ahb_HTRANS (htrans),
        .ldst2_ahb_HWRITE (hwrite),
        .ldst2_ahb_HADDR  (haddr),
        .r_ex2_memop_Q    (memop),
        .s_ex2_encoded_Q  (enc),
        .s_ex2_rd_Q       (rd),
        .ldst2_ahb_HREADY (hready),
        .ldst2_ahb_HRESP  (hresp),
        .ldst2_ahb_HRDATA (hrdata),
        .s_ex3_flush      (flush),
        .ldst2_ahb_HWDATA (hwdata),
        .s_ex3_stall_D    (stall),
        .s_ex3_wb_valid_D (wb_v),
        .s_ex3_wb_rd_D    (wb_rd),
        .s_ex3_wb_data_D  (wb_data),
        .s_ex3_exc_D      (exc),
        .s_ex3_exc_addr_D (exc_addr)
    );

    function automatic bit is_st(input logic [3:0] m);
        return m == 4'h1 || m == 4'h2 || m == 4'h3;
    endfunction

    function automatic bit is_ld(input logic [3:0] m);
        return m >= 4'h9 && m <= 4'hD;
    endfunction

    // Expected load value from the spec's arithmetic description.
    function automatic logic [31:0] ref_load(input logic [3:0] m, input logic [31:0] a,
                                             input logic [31:0] d);
        logic [31:0] sh, b, h;
        sh = d >> (8 * a[1:0]);
        b  = sh % 256;
        h  = sh % 65536;
        case (m)
            4'h9:    return (b >= 128) ? b - 32'd256 : b;
            4'hA:    return b;
            4'hB:    return (h >= 32768) ? h - 32'd65536 : h;
            4'hC:    return h;
            default: return sh;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        @(negedge CLK);
        chk({tag, "_hwdata"}, hwdata, 32'h0);
        chk({tag, "_stall"}, {31'd0, stall}, 32'h0);
        chk({tag, "_wbv"}, {31'd0, wb_v}, 32'h0);
        chk({tag, "_wbrd"}, {27'd0, wb_rd}, 32'h0);
        chk({tag, "_wbdata"}, wb_data, 32'h0);
        chk({tag, "_exc"}, {31'd0, exc}, 32'h0);
        chk({tag, "_excaddr"}, exc_addr, 32'h0);
        @(posedge CLK); #1;
    endtask

    task automatic idle_inputs();
        htrans = 2'h0; hwrite = 1'b0; haddr = '0; memop = '0; enc = '0; rd = '0;
        hready = 1'b1; hresp = 1'b0; hrdata = '0; flush = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle_inputs();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        m_busy = 0; m_err = 0; m_kill = 0;
        m_memop = '0; m_addr = '0; m_wdata = '0; m_rd = '0;
        d_v = 0; d_rd = '0; d_data = '0;
    endtask

    // One bus cycle: drive, check against the reference, advance the reference.
    task automatic cyc(input string tag, input logic [1:0] t, input logic [3:0] m,
                       input logic [31:0] a, input logic [31:0] e, input logic [4:0] r,
                       input logic rdy, input logic rsp, input logic [31:0] rdat,
                       input logic fl);
        bit          complete, err_exit, killed, e_v, e_exc;
        logic [31:0] e_hw, e_data, e_exa;
        logic [4:0]  e_rd;
        htrans = t; memop = m; hwrite = is_st(m); haddr = a; enc = e; rd = r;
        hready = rdy; hresp = rsp; hrdata = rdat; flush = fl;

        complete = m_busy && !m_err && rdy && !rsp;
        err_exit = m_busy && m_err && rdy && rsp;
        killed   = m_kill || fl;
        e_hw     = (m_busy && is_st(m_memop)) ? m_wdata : 32'h0;
        e_v      = complete && is_ld(m_memop) && !killed;
        e_rd     = e_v ? m_rd : 5'd0;
        e_data   = e_v ? ref_load(m_memop, m_addr, rdat) : 32'h0;
        e_exc    = err_exit && !killed;
        e_exa    = e_exc ? m_addr : 32'h0;

        @(negedge CLK);
        chk({tag, "_stall"}, {31'd0, stall}, {31'd0, m_busy && !(rdy && !rsp)});
        chk({tag, "_hwdata"}, hwdata, e_hw);
        chk({tag, "_exc"}, {31'd0, exc}, {31'd0, e_exc});
        chk({tag, "_excaddr"}, exc_addr, e_exa);
`ifdef EX3_LOAD_REG_EN
        chk({tag, "_wbv"}, {31'd0, wb_v}, {31'd0, d_v});
        chk({tag, "_wbrd"}, {27'd0, wb_rd}, {27'd0, d_rd});
        chk({tag, "_wbdata"}, wb_data, d_data);
        d_v = e_v; d_rd = e_rd; d_data = e_data;
`else
        chk({tag, "_wbv"}, {31'd0, wb_v}, {31'd0, e_v});
        chk({tag, "_wbrd"}, {27'd0, wb_rd}, {27'd0, e_rd});
        chk({tag, "_wbdata"}, wb_data, e_data);
`endif

        if (complete || err_exit) begin
            m_busy = 0; m_err = 0; m_kill = 0;
        end else begin
            if (m_busy && fl) m_kill = 1;
            if (m_busy && !m_err && !rdy && rsp) m_err = 1;
        end
        if (rdy && t == 2'h2 && !m_busy && !err_exit) begin
            m_busy = 1; m_err = 0; m_kill = 0;
            m_memop = m; m_addr = a; m_wdata = e; m_rd = r;
        end
        @(posedge CLK); #1;
    endtask

    localparam logic [1:0] NS = 2'h2;
    localparam logic [1:0] ID = 2'h0;

    initial begin
        logic [3:0]  ops [8];
        logic [3:0]  op;
        int          waits;
        ops = '{4'h1, 4'h2, 4'h3, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD};

        do_reset();
        chk_zero("reset");

        // 1. LW, zero wait states.
        cyc("lw_acc", NS, 4'hD, 32'h100, 32'h0, 5'd3, 1, 0, 32'h0, 0);
        cyc("lw_cmp", ID, 4'h0, 32'h0, 32'h0, 5'd0, 1, 0, 32'hDEADBEEF, 0);
        // 2. byte/half extension.
        cyc("lb_acc", NS, 4'h9, 32'h103, 32'h0, 5'd4, 1, 0, 32'h0, 0);
        cyc("lb_cmp", ID, 4'h0, 32'h0, 32'h0, 5'd0, 1, 0, 32'h80FF0000, 0);
        cyc("lbu_acc", NS, 4'hA, 32'h103, 32'h0, 5'd5, 1, 0, 32'h0, 0);
        cyc("lbu_cmp", ID, 4'h0, 32'h0, 32'h0, 5'd0, 1, 0, 32'h80FF0000, 0);
        cyc("lhu_acc", NS, 4'hC, 32'h102, 32'h0, 5'd6, 1, 0, 32'h0, 0);
        cyc("lhu_cmp", ID, 4'h0, 32'h0, 32'h0, 5'd0, 1, 0, 32'h80FF0000, 0);
        // 3. SW with three wait states.
        cyc("sw_acc", NS, 4'h3, 32'h200, 32'h12345678, 5'd0, 1, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++)
            cyc("sw_wait", ID, 4'h0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0, 0);
        cyc("sw_cmp", ID, 4'h0, 32'h0, 32'h0, 5'd0, 1, 0, 32'h0, 0);
        // 4. back-to-back LW/LW.
        cyc("b2b_acc", NS, 4'hD, 32'h10, 32'h0, 5'd7, 1, 0, 32'h0, 0);
        cyc("b2b_1", NS, 4'hD, 32'h14, 32'h0, 5'd8, 1, 0, 32'hA5A5A5A5, 0);
        cyc("b2b_2", ID, 4'h0, 32'h0, 32'h0, 5'd0, 1, 0, 32'h5A5A0001, 0);
        // 5. ERROR response.
        cyc("err_acc", NS, 4'hD, 32'h40, 32'h0, 5'd9, 1, 0, 32'h0, 0);
        cyc("err_1", ID, 4'h0, 32'h0, 32'h0, 5'd0, 0, 1, 32'h0, 0);
        cyc("err_2", ID, 4'h0, 32'h0, 32'h0, 5'd0, 1, 1, 32'h0, 0);
        cyc("err_idle", ID, 4'h0, 32'h0, 32'h0, 5'd0, 1, 0, 32'h0, 0);
        // 6. flush during a wait state of LH.
        cyc("fl_acc", NS, 4'hB, 32'h22, 32'h0, 5'd10, 1, 0, 32'h0, 0);
        cyc("fl_w1", ID, 4'h0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0, 1);
        cyc("fl_w2", ID, 4'h0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0, 0);
        cyc("fl_cmp", ID, 4'h0, 32'h0, 32'h0, 5'd0, 1, 0, 32'h8001FFFF, 0);
        // Flushed error is silent too.
        cyc("fe_acc", NS, 4'hD, 32'h44, 32'h0, 5'd1, 1, 0, 32'h0, 0);
        cyc("fe_1", ID, 4'h0, 32'h0, 32'h0, 5'd0, 0, 1, 32'h0, 1);
        cyc("fe_2", ID, 4'h0, 32'h0, 32'h0, 5'd0, 1, 1, 32'h0, 0);
        // RST mid-DATA: completion inputs present while reset, nothing emitted after.
        cyc("rst_acc", NS, 4'hD, 32'h80, 32'h0, 5'd2, 1, 0, 32'h0, 0);
        RST = 1'b1;
        hready = 1'b0; htrans = ID;
        @(posedge CLK); #1;
        do_reset();
        hready = 1'b1; hrdata = 32'hFFFFFFFF;
        chk_zero("rst_mid");

        // Random traffic: loads/stores, 0..3 waits, random flush, optional overlap.
        for (int n = 0; n < 150; n++) begin
            if (!m_busy) begin
                op = ops[$urandom_range(0, 7)];
                cyc("rnd_acc", NS, op, $urandom, $urandom, 5'($urandom), 1, 0, $urandom, 0);
            end
            waits = $urandom_range(0, 3);
            for (int w = 0; w < waits; w++)
                cyc("rnd_wait", ID, 4'h0, $urandom, 32'h0, 5'd0, 0, 0, $urandom,
                    ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 1) == 1) begin
                op = ops[$urandom_range(0, 7)];
                cyc("rnd_b2b", NS, op, $urandom, $urandom, 5'($urandom), 1, 0, $urandom,
                    ($urandom_range(0, 7) == 0));
            end else begin
                cyc("rnd_cmp", ID, 4'h0, $urandom, 32'h0, 5'd0, 1, 0, $urandom,
                    ($urandom_range(0, 7) == 0));
            end
        end
        cyc("rnd_drain", ID, 4'h0, 32'h0, 32'h0, 5'd0, 1, 0, 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
